// File: rtl/byte_serial_subtractor.sv
// byte_serial_subtractor: element-wide a - b - borrow computed one byte per cycle.
// The borrow travels between bytes as an active-high carry (a + ~b + carry).
// The first carry is ~borrow_i. The final borrow is the inverse of the last carry.
module byte_serial_subtractor #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [MAX_BYTES*8-1:0] a_i,
  input  logic [MAX_BYTES*8-1:0] b_i,
  input  logic                   borrow_i,
  input  logic [1:0]             sew_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [MAX_BYTES*8-1:0] diff_o,
  output logic                   borrow_o,
  output logic                   ovf_o
);

  localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef logic [MAX_BYTES-1:0][7:0] bytes_t;

  state_e        state_q, state_d;
  bytes_t        a_q, b_q, diff_q;
  logic [IW-1:0] cnt_q, last_q, last_req;
  logic          carry_q;
  logic          accept;
  logic [8:0]    sum;

  // Index of the top byte of the element; wide SEW clamps to the datapath width.
  function automatic logic [IW-1:0] last_index(input logic [1:0] sew);
    int nb;
    nb = 1 << sew;
    if (nb > MAX_BYTES) nb = MAX_BYTES;
    return IW'(nb - 1);
  endfunction

  assign last_req = last_index(sew_i);
  assign accept   = in_valid_i & in_ready_o;
  assign sum      = {1'b0, a_q[cnt_q]} + {1'b0, ~b_q[cnt_q]} + 9'(carry_q);
  assign diff_o   = diff_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake/result outputs.
  // borrow_o and ovf_o are forced low outside DONE.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    borrow_o    = 1'b0;
    ovf_o       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == last_q) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        borrow_o    = ~carry_q;
        ovf_o       = (a_q[last_q][7] != b_q[last_q][7]) &
                      (diff_q[last_q][7] != a_q[last_q][7]);
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on acceptance and one byte of ripple-borrow per BUSY cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= a_i;
          b_q     <= b_i;
          last_q  <= last_req;
          cnt_q   <= '0;
          carry_q <= ~borrow_i;
          diff_q  <= '0;
        end
        BUSY: begin
          diff_q[cnt_q] <= sum[7:0];
          carry_q       <= sum[8];
          cnt_q         <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Directed plus random bench for byte_serial_subtractor.
// A plain-arithmetic reference model supplies every expected value.
module tb_byte_serial_subtractor;

  localparam int MB = 8;
  localparam int W  = MB * 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out, ovf;
  logic [W-1:0] a, b, diff;
  logic [1:0]   sew;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  byte_serial_subtractor #(.MAX_BYTES(MB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .borrow_i   (borrow_in),
    .sew_i      (sew),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .diff_o     (diff),
    .borrow_o   (borrow_out),
    .ovf_o      (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit modular difference, unsigned borrow, signed range overflow.
  function automatic void model(input logic [1:0] s, input logic [63:0] av, input logic [63:0] bv,
                                input logic bi, output logic [63:0] d, output logic bo,
                                output logic ov);
    int                 w;
    logic [63:0]        mask;
    logic [65:0]        am, bm;
    logic signed [67:0] sa, sb, sd, hi, lo;
    w    = (1 << s) * 8;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = {2'b00, av & mask};
    bm   = {2'b00, bv & mask};
    d    = (av - bv - 64'(bi)) & mask;
    bo   = (am < bm + 66'(bi));
    sa   = $signed({2'b00, am});
    sb   = $signed({2'b00, bm});
    if (av[w-1]) sa = sa - (68'sd1 <<< w);
    if (bv[w-1]) sb = sb - (68'sd1 <<< w);
    sd   = sa - sb;
    if (bi) sd = sd - 68'sd1;
    hi   = (68'sd1 <<< (w - 1)) - 68'sd1;
    lo   = -(68'sd1 <<< (w - 1));
    ov   = (sd > hi) || (sd < lo);
  endfunction

  // One full transaction. hold = cycles of backpressure in DONE.
  // press keeps in_valid high with junk operands after acceptance.
  task automatic run_op(input string tag, input logic [1:0] s, input logic [63:0] av,
                        input logic [63:0] bv, input logic bi, input int hold, input bit press);
    int          n, edges, waitc;
    logic [63:0] ed;
    logic        eb, eo;
    n = 1 << s;
    model(s, av, bv, bi, ed, eb, eo);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = av; b = bv; sew = s; borrow_in = bi;
    waitc = 0;
    while (!in_ready && waitc < 20) begin step(); waitc++; end
    chk({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    step();                       // accepting edge
    edges = 1;
    in_valid = press;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sew = 2'($urandom); borrow_in = 1'($urandom);
    while (!out_valid && edges < 20) begin
      chk({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
      step();
      edges++;
    end
    // The count includes the accepting edge.
    chk({tag, "_latency"}, 64'(edges), 64'(n + 1));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_diff"}, diff, ed);
    end
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, 64'(borrow_out), 64'(eb));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    step();                       // release edge; in_valid may still be high
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_rel_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sew = 2'b00; borrow_in = 1'b0;
    step(); step(); step();
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_borrow", 64'(borrow_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    run_op("b5m3", 2'b00, 64'h05, 64'h03, 1'b0, 0, 1'b0);
    run_op("b0m1", 2'b00, 64'h00, 64'h01, 1'b0, 0, 1'b0);
    run_op("b80m1", 2'b00, 64'h80, 64'h01, 1'b0, 0, 1'b0);
    run_op("d64", 2'b11, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 0, 1'b0);
    run_op("h16eq", 2'b01, 64'hDEAD_BEEF_CAFE_1234, 64'h5555_AAAA_0F0F_1234, 1'b1, 0, 1'b0);
    run_op("bp", 2'b10, 64'h1234_5678_8000_0000, 64'h0000_0000_0000_0001, 1'b0, 5, 1'b1);

    // Reset in the middle of a 32-bit operation.
    in_valid = 1'b1; sew = 2'b10; a = 64'hFFFF_FFFF; b = 64'h1; borrow_in = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    chk("mid_rst_diff", diff, 64'd0);
    run_op("post_rst", 2'b00, 64'h3C, 64'h4D, 1'b1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("rnd", 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
